// File: rtl/echo_pkg.sv
// Shared definitions for the echo FIFO output stage: the serializer FSM encoding
// and the beat-index sizing used by fifo_beat_serializer.
package echo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // A single-beat word still needs a one-bit beat index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_DATA_WIDTH = 128;
  localparam int DEF_BEAT_WIDTH = 32;
  localparam int NBEATS         = DEF_DATA_WIDTH / DEF_BEAT_WIDTH;
  localparam int BEAT_IDX_W     = idx_width(NBEATS);

endpackage

// File: rtl/fifo_beat_serializer.sv
// Pops wide words from the upstream FIFO and replays them as narrow beats,
// least-significant beat first, with zero-bubble reload and a completed-word counter.
module fifo_beat_serializer
  import echo_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int BEAT_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [DATA_WIDTH-1:0] in_first,
  input  logic                  in_first__RDY,
  output logic                  in_deq__ENA,
  input  logic                  in_deq__RDY,
  output logic                  out_enq__ENA,
  output logic [BEAT_WIDTH-1:0] out_enq_v,
  output logic                  out_enq_last,
  input  logic                  out_enq__RDY,
  output logic [CNT_WIDTH-1:0]  words_sent
);

  localparam int NB  = DATA_WIDTH / BEAT_WIDTH;
  localparam int BIW = idx_width(NB);
  localparam logic [BIW-1:0] LAST_BEAT = BIW'(NB - 1);

  state_t                  state;
  state_t                  state_next;
  logic [DATA_WIDTH-1:0]   shreg;
  logic [BIW-1:0]          beat;
  logic                    busy;
  logic                    last_xfer;
  logic                    load;

  assign busy = (state == SEND);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (load) state_next = SEND;
      SEND:    if (last_xfer && !load) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Load is gated by nRST so no pop can leak out while reset is held.
  always_comb begin
    out_enq__ENA = busy & out_enq__RDY;
    out_enq_last = busy & (beat == LAST_BEAT);
    out_enq_v    = shreg[BEAT_WIDTH-1:0];
    last_xfer    = out_enq__ENA & out_enq_last;
    load         = nRST & in_first__RDY & in_deq__RDY & (~busy | last_xfer);
    in_deq__ENA  = load;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      shreg      <= '0;
      beat       <= '0;
      words_sent <= '0;
    end else begin
      if (load) begin
        shreg <= in_first;
        beat  <= '0;
      end else if (out_enq__ENA && !out_enq_last) begin
        shreg <= shreg >> BEAT_WIDTH;
        beat  <= beat + BIW'(1);
      end
      if (last_xfer) begin
        words_sent <= words_sent + CNT_WIDTH'(1);
      end
    end
  end

endmodule
